// File: rtl/local_hist_predictor.sv
// local_hist_predictor
//   Two-level local-history conditional branch direction predictor for fetch.
//   A per-address branch history table (BHT) feeds the index of a shared
//   pattern history table (PHT) of saturating counters:
//     BHT index = PC[2 +: BHT_IDX_BITS]
//     PHT index = PC[2 +: PHT_IDX_BITS] ^ zext(local history)
//   The history is updated speculatively at predict time. The resolve ports
//   train the counters and repair the history after a mispredict.
//   After reset a built-in sequencer sweeps both tables before 'ready' rises.
//
// Ports
//   clk, rst                  clock, asynchronous active-low reset
//   stall                     hold prediction outputs, suppress fetch writes
//   fetchValid/PC/CondBr      fetch group request (lane i PC = fetchPC + 4*i)
//   ready                     init sweep complete
//   predValid/Taken/Hist/Ctr  registered prediction, one cycle after request
//   updValid/PC/Hist/Ctr/
//   updTaken/updMispred       branch-resolve ports (training and repair)
//
// Build option
//   LOCAL_PRED_BYPASS_EN      when defined, same-cycle repair and training
//                             writes are forwarded to fetch reads
module local_hist_predictor #(
    parameter int unsigned FETCH_WIDTH  = 2,
    parameter int unsigned UPDATE_WIDTH = 2,
    parameter int unsigned ADDR_W       = 32,
    parameter int unsigned BHT_IDX_BITS = 8,
    parameter int unsigned PHT_IDX_BITS = 10,
    parameter int unsigned HIST_BITS    = 8,
    parameter int unsigned CTR_BITS     = 2
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic                              stall,
    input  logic                              fetchValid,
    input  logic [ADDR_W-1:0]                 fetchPC,
    input  logic [FETCH_WIDTH-1:0]            fetchCondBr,
    output logic                              ready,
    output logic                              predValid,
    output logic [FETCH_WIDTH-1:0]            predTaken,
    output logic [FETCH_WIDTH*HIST_BITS-1:0]  predHist,
    output logic [FETCH_WIDTH*CTR_BITS-1:0]   predCtr,
    input  logic [UPDATE_WIDTH-1:0]           updValid,
    input  logic [UPDATE_WIDTH*ADDR_W-1:0]    updPC,
    input  logic [UPDATE_WIDTH*HIST_BITS-1:0] updHist,
    input  logic [UPDATE_WIDTH*CTR_BITS-1:0]  updCtr,
    input  logic [UPDATE_WIDTH-1:0]           updTaken,
    input  logic [UPDATE_WIDTH-1:0]           updMispred
);

    localparam int unsigned BHT_N     = 1 << BHT_IDX_BITS;
    localparam int unsigned PHT_N     = 1 << PHT_IDX_BITS;
    localparam int unsigned INIT_BITS = (BHT_IDX_BITS > PHT_IDX_BITS) ? BHT_IDX_BITS : PHT_IDX_BITS;

    localparam logic [0:0] ST_INIT  = 1'b0;
    localparam logic [0:0] ST_READY = 1'b1;

    localparam logic [CTR_BITS-1:0] CTR_WEAK_T = CTR_BITS'(1 << (CTR_BITS - 1));
    localparam logic [CTR_BITS-1:0] CTR_MAX    = '1;

    logic [0:0]           state_q, state_d;
    logic [INIT_BITS-1:0] init_idx_q, init_idx_d;

    logic [HIST_BITS-1:0] bht_q [BHT_N];
    logic [CTR_BITS-1:0]  pht_q [PHT_N];

    logic                              pred_valid_q;
    logic [FETCH_WIDTH-1:0]            pred_taken_q, pred_taken_d;
    logic [FETCH_WIDTH*HIST_BITS-1:0]  pred_hist_q, pred_hist_d;
    logic [FETCH_WIDTH*CTR_BITS-1:0]   pred_ctr_q, pred_ctr_d;

    logic                    fetch_go;
    logic                    upd_on;
    logic                    taken_seen;
    logic [FETCH_WIDTH-1:0]  lane_wr;
    logic [BHT_IDX_BITS-1:0] lane_bidx [FETCH_WIDTH];
    logic [PHT_IDX_BITS-1:0] lane_pidx [FETCH_WIDTH];
    logic [HIST_BITS-1:0]    lane_hist [FETCH_WIDTH];
    logic [CTR_BITS-1:0]     lane_ctr  [FETCH_WIDTH];

    logic [UPDATE_WIDTH-1:0] upd_trn_en, upd_rep_en;
    logic [BHT_IDX_BITS-1:0] upd_bidx    [UPDATE_WIDTH];
    logic [PHT_IDX_BITS-1:0] upd_pidx    [UPDATE_WIDTH];
    logic [CTR_BITS-1:0]     upd_ctr_cur [UPDATE_WIDTH];
    logic [CTR_BITS-1:0]     upd_ctr_nx  [UPDATE_WIDTH];
    logic [HIST_BITS-1:0]    upd_rep_val [UPDATE_WIDTH];

    logic unused_pc_bits;
    assign unused_pc_bits = ^{fetchPC, updPC};

    assign ready     = (state_q == ST_READY);
    assign fetch_go  = ready & fetchValid & ~stall;
    assign upd_on    = ready;
    assign predValid = pred_valid_q;
    assign predTaken = pred_taken_q;
    assign predHist  = pred_hist_q;
    assign predCtr   = pred_ctr_q;

    // Init sequencer: one index per cycle over the larger of the two tables.
    always_comb begin
        state_d    = state_q;
        init_idx_d = init_idx_q;
        if (state_q == ST_INIT) begin
            init_idx_d = init_idx_q + INIT_BITS'(1);
            if (init_idx_q == '1) begin
                state_d    = ST_READY;
                init_idx_d = '0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= ST_INIT;
            init_idx_q <= '0;
        end else begin
            state_q    <= state_d;
            init_idx_q <= init_idx_d;
        end
    end

    // Resolve ports: training target, saturated counter and repaired history.
    always_comb begin
        for (int unsigned k = 0; k < UPDATE_WIDTH; k++) begin
            upd_trn_en[k]  = upd_on & updValid[k];
            upd_rep_en[k]  = upd_on & updValid[k] & updMispred[k];
            upd_bidx[k]    = updPC[k*ADDR_W+2 +: BHT_IDX_BITS];
            upd_pidx[k]    = updPC[k*ADDR_W+2 +: PHT_IDX_BITS]
                             ^ PHT_IDX_BITS'(updHist[k*HIST_BITS +: HIST_BITS]);
            upd_ctr_cur[k] = updCtr[k*CTR_BITS +: CTR_BITS];
            upd_ctr_nx[k]  = upd_ctr_cur[k];
            if (updTaken[k]) begin
                if (upd_ctr_cur[k] != CTR_MAX) upd_ctr_nx[k] = upd_ctr_cur[k] + CTR_BITS'(1);
            end else begin
                if (upd_ctr_cur[k] != '0) upd_ctr_nx[k] = upd_ctr_cur[k] - CTR_BITS'(1);
            end
            upd_rep_val[k] = {updHist[k*HIST_BITS +: HIST_BITS-1], updTaken[k]};
        end
    end

    // Fetch lanes. PC[2 +: N] + i equals (PC + 4*i)[2 +: N] since carries
    // only move upward, so the full lane PC never needs to be formed.
    always_comb begin
        taken_seen   = 1'b0;
        lane_wr      = '0;
        pred_taken_d = '0;
        pred_hist_d  = '0;
        pred_ctr_d   = '0;
        for (int unsigned i = 0; i < FETCH_WIDTH; i++) begin
            lane_bidx[i] = fetchPC[2 +: BHT_IDX_BITS] + BHT_IDX_BITS'(i);
            lane_hist[i] = bht_q[lane_bidx[i]];
`ifdef LOCAL_PRED_BYPASS_EN
            for (int unsigned k = 0; k < UPDATE_WIDTH; k++) begin
                if (upd_rep_en[k] && (upd_bidx[k] == lane_bidx[i])) lane_hist[i] = upd_rep_val[k];
            end
`endif
            lane_pidx[i] = (fetchPC[2 +: PHT_IDX_BITS] + PHT_IDX_BITS'(i))
                           ^ PHT_IDX_BITS'(lane_hist[i]);
            lane_ctr[i]  = pht_q[lane_pidx[i]];
`ifdef LOCAL_PRED_BYPASS_EN
            for (int unsigned k = 0; k < UPDATE_WIDTH; k++) begin
                if (upd_trn_en[k] && (upd_pidx[k] == lane_pidx[i])) lane_ctr[i] = upd_ctr_nx[k];
            end
`endif
            // Lanes past the first predicted-taken lane are dead: no taken, no write.
            lane_wr[i]      = fetchCondBr[i] & ~taken_seen;
            pred_taken_d[i] = fetchCondBr[i] & lane_ctr[i][CTR_BITS-1] & ~taken_seen;
            if (pred_taken_d[i]) taken_seen = 1'b1;
            pred_hist_d[i*HIST_BITS +: HIST_BITS] = lane_hist[i];
            pred_ctr_d[i*CTR_BITS +: CTR_BITS]    = lane_ctr[i];
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pred_valid_q <= 1'b0;
            pred_taken_q <= '0;
            pred_hist_q  <= '0;
            pred_ctr_q   <= '0;
        end else if (state_q != ST_READY) begin
            pred_valid_q <= 1'b0;
        end else if (!stall) begin
            pred_valid_q <= fetchValid;
            if (fetchValid) begin
                pred_taken_q <= pred_taken_d;
                pred_hist_q  <= pred_hist_d;
                pred_ctr_q   <= pred_ctr_d;
            end
        end
    end

    // Table writes. Statement order encodes priority (last write wins):
    // speculative lanes ascending, then training and repair by ascending port.
    always_ff @(posedge clk) begin
        if (state_q == ST_INIT) begin
            if (32'(init_idx_q) < BHT_N) bht_q[init_idx_q[BHT_IDX_BITS-1:0]] <= '0;
            if (32'(init_idx_q) < PHT_N) pht_q[init_idx_q[PHT_IDX_BITS-1:0]] <= CTR_WEAK_T;
        end else begin
            if (fetch_go) begin
                for (int unsigned i = 0; i < FETCH_WIDTH; i++) begin
                    if (lane_wr[i]) bht_q[lane_bidx[i]] <= {lane_hist[i][HIST_BITS-2:0], pred_taken_d[i]};
                end
            end
            for (int unsigned k = 0; k < UPDATE_WIDTH; k++) begin
                if (upd_trn_en[k]) pht_q[upd_pidx[k]] <= upd_ctr_nx[k];
            end
            for (int unsigned k = 0; k < UPDATE_WIDTH; k++) begin
                if (upd_rep_en[k]) bht_q[upd_bidx[k]] <= upd_rep_val[k];
            end
        end
    end

endmodule

// File: tb/tb_local_hist_predictor.sv
module tb_local_hist_predictor;

    logic        clk;
    logic        rst;
    logic        stall;
    logic        fetchValid;
    logic [31:0] fetchPC;
    logic [1:0]  fetchCondBr;
    logic        ready;
    logic        predValid;
    logic [1:0]  predTaken;
    logic [15:0] predHist;
    logic [3:0]  predCtr;
    logic [1:0]  updValid;
    logic [63:0] updPC;
    logic [15:0] updHist;
    logic [3:0]  updCtr;
    logic [1:0]  updTaken;
    logic [1:0]  updMispred;

    int unsigned n_cmp = 0;
    int unsigned n_err = 0;
    int unsigned cycles;

    local_hist_predictor #(
        .FETCH_WIDTH (2),
        .UPDATE_WIDTH(2),
        .ADDR_W      (32),
        .BHT_IDX_BITS(8),
        .PHT_IDX_BITS(10),
        .HIST_BITS   (8),
        .CTR_BITS    (2)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .stall      (stall),
        .fetchValid (fetchValid),
        .fetchPC    (fetchPC),
        .fetchCondBr(fetchCondBr),
        .ready      (ready),
        .predValid  (predValid),
        .predTaken  (predTaken),
        .predHist   (predHist),
        .predCtr    (predCtr),
        .updValid   (updValid),
        .updPC      (updPC),
        .updHist    (updHist),
        .updCtr     (updCtr),
        .updTaken   (updTaken),
        .updMispred (updMispred)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached before summary");
        $fatal(1);
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_upd(input int unsigned k, input logic [31:0] pc, input logic [7:0] hist,
                           input logic [1:0] ctr, input logic taken, input logic mis);
        updValid[k]          = 1'b1;
        updPC[k*32 +: 32]    = pc;
        updHist[k*8 +: 8]    = hist;
        updCtr[k*2 +: 2]     = ctr;
        updTaken[k]          = taken;
        updMispred[k]        = mis;
    endtask

    task automatic clear_upd();
        updValid   = '0;
        updPC      = '0;
        updHist    = '0;
        updCtr     = '0;
        updTaken   = '0;
        updMispred = '0;
    endtask

    task automatic do_fetch(input logic [31:0] pc, input logic [1:0] cond);
        fetchValid  = 1'b1;
        fetchPC     = pc;
        fetchCondBr = cond;
        tick();
        fetchValid  = 1'b0;
        fetchCondBr = '0;
    endtask

    // Counts edges after reset release until ready; with poke set it also
    // probes the sweep: fetches must stay invalid and updates must be dropped.
    task automatic wait_ready(output int unsigned cnt, input bit poke);
        cnt = 0;
        if (poke) begin
            fetchValid  = 1'b1;
            fetchPC     = 32'h100;
            fetchCondBr = 2'b01;
        end
        while (!ready && cnt < 1200) begin
            tick();
            cnt++;
            if (poke && cnt == 500) begin
                check("init_pvalid", predValid, 0);
                check("init_phist", predHist, 0);
            end
            if (poke && cnt == 1000) set_upd(0, 32'h100, 8'h00, 2'd0, 1'b1, 1'b1);
            if (poke && cnt == 1001) clear_upd();
        end
        fetchValid  = 1'b0;
        fetchCondBr = '0;
        clear_upd();
    endtask

    initial begin
        rst         = 1'b0;
        stall       = 1'b0;
        fetchValid  = 1'b1;
        fetchPC     = 32'h100;
        fetchCondBr = 2'b11;
        clear_upd();
        repeat (3) tick();
        check("rst_ready", ready, 0);
        check("rst_pvalid", predValid, 0);
        check("rst_ptaken", predTaken, 0);
        check("rst_phist", predHist, 0);
        check("rst_pctr", predCtr, 0);
        fetchValid  = 1'b0;
        fetchCondBr = '0;

        // T1: sweep length and first prediction from freshly initialised tables
        rst = 1'b1;
        wait_ready(cycles, 1'b1);
        check("t1_ready_lat", (cycles == 1024 || cycles == 1025), 1);
        do_fetch(32'h100, 2'b01);
        check("t1_pvalid", predValid, 1);
        check("t1_ptaken", predTaken, 2'b01);
        check("t1_ctr0", predCtr[1:0], 2);
        check("t1_phist", predHist, 0);
        tick();
        check("t1_vdrop", predValid, 0);
        check("t1_hold_taken", predTaken, 2'b01);

        // T2: speculative history shift after the taken prediction
        do_fetch(32'h100, 2'b01);
        check("t2_hist0", predHist[7:0], 8'h01);
        check("t2_taken", predTaken, 2'b01);

        // T3: both lanes cond and weakly taken -> only lane 0 taken
        do_fetch(32'h100, 2'b11);
        check("t3_taken", predTaken, 2'b01);
        check("t3_hist", predHist, 16'h0003);
        do_fetch(32'h104, 2'b01);
        check("t3_lane1_bht", predHist[7:0], 8'h00);

        // T4: counter saturation and a plain decrement
        set_upd(0, 32'h200, 8'h00, 2'd3, 1'b1, 1'b0);
        tick();
        clear_upd();
        do_fetch(32'h200, 2'b01);
        check("t4_sat_hi", predCtr[1:0], 3);
        set_upd(0, 32'h300, 8'h00, 2'd0, 1'b0, 1'b0);
        tick();
        clear_upd();
        do_fetch(32'h300, 2'b11);
        check("t4_sat_lo_ctr", predCtr, 4'b1000);
        check("t4_sat_lo_taken", predTaken, 2'b10);
        set_upd(0, 32'h400, 8'h00, 2'd2, 1'b0, 1'b0);
        tick();
        clear_upd();
        do_fetch(32'h400, 2'b01);
        check("t4_dec_ctr", predCtr[1:0], 1);
        check("t4_dec_taken", predTaken, 2'b00);

        // T5: repair beats same-cycle speculative write
        fetchValid  = 1'b1;
        fetchPC     = 32'h020;
        fetchCondBr = 2'b01;
        set_upd(0, 32'h020, 8'h05, 2'd2, 1'b0, 1'b1);
        tick();
        fetchValid  = 1'b0;
        fetchCondBr = '0;
        clear_upd();
        check("t5_spec_taken", predTaken, 2'b01);
        check("t5_spec_hist", predHist[7:0], 8'h00);
        do_fetch(32'h020, 2'b01);
        check("t5_repair_hist", predHist[7:0], 8'h0A);
        check("t5_repair_ctr", predCtr[1:0], 2);

        // T5: two ports on the same BHT and PHT entry -> port 1 wins both
        set_upd(0, 32'h040, 8'h00, 2'd3, 1'b1, 1'b1);
        set_upd(1, 32'h040, 8'h00, 2'd0, 1'b0, 1'b1);
        tick();
        clear_upd();
        do_fetch(32'h040, 2'b01);
        check("t5_port_hist", predHist[7:0], 8'h00);
        check("t5_port_ctr", predCtr[1:0], 0);
        check("t5_port_taken", predTaken, 2'b00);

        // T6: stall holds outputs and blocks speculative writes; updates still apply
        do_fetch(32'h100, 2'b01);
        check("st_pre_hist", predHist, 16'h0107);
        stall       = 1'b1;
        fetchValid  = 1'b1;
        fetchPC     = 32'h100;
        fetchCondBr = 2'b01;
        set_upd(0, 32'h080, 8'h00, 2'd0, 1'b0, 1'b0);
        for (int unsigned c = 0; c < 3; c++) begin
            tick();
            clear_upd();
            check("st_valid", predValid, 1);
            check("st_hist", predHist, 16'h0107);
            check("st_taken", predTaken, 2'b01);
            check("st_ctr", predCtr, 4'hA);
        end
        stall       = 1'b0;
        fetchValid  = 1'b0;
        fetchCondBr = '0;
        do_fetch(32'h100, 2'b01);
        check("st_bht", predHist[7:0], 8'h0F);
        do_fetch(32'h080, 2'b01);
        check("st_upd", predCtr[1:0], 0);

        // T6: asynchronous reset, then reset again mid-sweep restarts from 0
        do_fetch(32'h100, 2'b01);
        rst = 1'b0;
        #1;
        check("t6_ready", ready, 0);
        check("t6_pvalid", predValid, 0);
        check("t6_ptaken", predTaken, 0);
        check("t6_phist", predHist, 0);
        check("t6_pctr", predCtr, 0);
        tick();
        rst = 1'b1;
        repeat (300) tick();
        check("t6_mid_ready", ready, 0);
        rst = 1'b0;
        repeat (2) tick();
        rst = 1'b1;
        wait_ready(cycles, 1'b0);
        check("t6_restart_lat", (cycles == 1024 || cycles == 1025), 1);
        do_fetch(32'h100, 2'b01);
        check("t6_reinit_hist", predHist[7:0], 8'h00);
        check("t6_reinit_ctr", predCtr[1:0], 2);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
